// File: rtl/mbist_march_ctrl_if.sv
// Bus bundle between the March C- controller, its external address counter,
// the memory under test and the status consumer.
// master: controller side. slave: environment side (counter, memory, host).
interface mbist_march_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d_in;
  logic              cnt_ld;
  logic              cnt_u_d;
  logic              cnt_cen;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  modport master (
    input  start, cnt_q, mem_rdata,
    output cnt_d_in, cnt_ld, cnt_u_d, cnt_cen, mem_en, mem_we, mem_addr, mem_wdata,
    output busy, done, fail, fail_addr, fail_elem
  );

  modport slave (
    output start, cnt_q, mem_rdata,
    input  cnt_d_in, cnt_ld, cnt_u_d, cnt_cen, mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, done, fail, fail_addr, fail_elem
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: steers an external up/down address counter, issues
// read/write strobes with all-0/all-1 backgrounds, compares read data one cycle
// later and latches the address/element of the first miscompare.
// Optional: define MBIST_FAIL_STOP_EN to abort the run at the first miscompare.
module mbist_march_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input logic                clk,
  input logic                rst,
  mbist_march_ctrl_if.master bus
);
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StOp1   = 3'd2;
  localparam logic [2:0] StOp2   = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [2:0]        LastElem = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [2:0]        cmp_elem_q, cmp_elem_d;

  logic              dir_up, single_op, rd_bit, wr2_bit, at_end, adv, mismatch;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic              cnt_cen, cnt_ld, cnt_u_d, mem_en, mem_we;
  logic [ADDR_W-1:0] cnt_d_in;
  logic [DATA_W-1:0] mem_wdata;

  // Per-element attributes: direction, op count, expected read and second-op write value
  always_comb begin
    dir_up     = (elem_q != 3'd3) && (elem_q != 3'd4);
    single_op  = (elem_q == 3'd0) || (elem_q == LastElem);
    rd_bit     = (elem_q == 3'd2) || (elem_q == 3'd4);
    wr2_bit    = (elem_q == 3'd1) || (elem_q == 3'd3);
    start_addr = dir_up ? '0 : AddrMax;
    end_addr   = dir_up ? AddrMax : '0;
    at_end     = (bus.cnt_q == end_addr);
  end

  assign mismatch = cmp_vld_q && (bus.mem_rdata != cmp_exp_q);

  // Sequencing plus combinational counter/memory decode
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    cnt_cen   = 1'b0;
    cnt_ld    = 1'b0;
    cnt_u_d   = 1'b0;
    cnt_d_in  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    adv       = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          elem_d  = '0;
        end
      end
      StLoad: begin
        cnt_cen  = 1'b1;
        cnt_ld   = 1'b1;
        cnt_d_in = start_addr;
        state_d  = StOp1;
      end
      StOp1: begin
        mem_en = 1'b1;
        mem_we = (elem_q == 3'd0);  // E0 writes 0, every other first op is a read
        if (single_op) adv = 1'b1;
        else           state_d = StOp2;
      end
      StOp2: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = {DATA_W{wr2_bit}};
        adv       = 1'b1;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Last address of an element goes back through LOAD so the counter never wraps
    if (adv) begin
      if (!at_end) begin
        cnt_cen = 1'b1;
        cnt_u_d = dir_up;
        state_d = StOp1;
      end else if (elem_q == LastElem) begin
        state_d = StDrain;
      end else begin
        elem_d  = elem_q + 3'd1;
        state_d = StLoad;
      end
    end
`ifdef MBIST_FAIL_STOP_EN
    if (mismatch && !fail_q) state_d = StDone;
`endif
  end

  // Read-compare pipeline and sticky first-failure capture
  always_comb begin
    cmp_vld_d   = mem_en && !mem_we;
    cmp_exp_d   = {DATA_W{rd_bit}};
    cmp_addr_d  = bus.cnt_q;
    cmp_elem_d  = elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (state_q == StIdle && bus.start) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
`ifdef MBIST_FAIL_STOP_EN
      cmp_vld_d   = 1'b0;
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      elem_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

  assign bus.cnt_cen   = cnt_cen;
  assign bus.cnt_ld    = cnt_ld;
  assign bus.cnt_u_d   = cnt_u_d;
  assign bus.cnt_d_in  = cnt_d_in;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = bus.cnt_q;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = (state_q == StLoad) || (state_q == StOp1) || (state_q == StOp2) ||
                         (state_q == StDrain);
  assign bus.done      = (state_q == StDone);
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_elem = fail_elem_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: counter and faulty-memory models, a March C-
// reference that expands the algorithm into expected per-cycle outputs, and a
// monitor that pops and compares them against the DUT.
module tb_mbist_march_ctrl;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 8;
  localparam int          NA = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Stuck-at fault, applied when a cell is read
  bit flt_en   = 1'b0;
  int flt_addr = 0;
  int flt_bit  = 0;
  bit flt_val  = 1'b0;

  function automatic logic [DW-1:0] faulty(int a, logic [DW-1:0] v);
    logic [DW-1:0] m;
    m = DW'(1) << flt_bit;
    if (flt_en && a == flt_addr) return flt_val ? (v | m) : (v & ~m);
    return v;
  endfunction

  logic [DW-1:0] mem [NA];
  logic [AW-1:0] cnt_q_r;
  logic [DW-1:0] rdata_r;
  assign bus.cnt_q     = cnt_q_r;
  assign bus.mem_rdata = rdata_r;

  // External up/down counter with load
  always @(posedge clk) begin
    if (bus.cnt_cen) begin
      if (bus.cnt_ld)       cnt_q_r <= bus.cnt_d_in;
      else if (bus.cnt_u_d) cnt_q_r <= cnt_q_r + AW'(1);
      else                  cnt_q_r <= cnt_q_r - AW'(1);
    end
  end

  // Synchronous memory: read data appears the cycle after the read
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) rdata_r <= faulty(int'(bus.mem_addr), mem[bus.mem_addr]);
  end

  typedef struct {
    int            cyc;
    logic          busy, done, mem_en, mem_we, cnt_cen, cnt_ld, cnt_u_d, fail;
    logic [AW-1:0] addr, d_in, faddr;
    logic [DW-1:0] wdata;
    logic [2:0]    felem;
  } rec_t;

  rec_t exp_q[$];

  function automatic rec_t idle_rec();
    rec_t r;
    r.cyc = 0;    r.busy = 0;    r.done = 0;    r.mem_en = 0;  r.mem_we = 0;
    r.cnt_cen = 0; r.cnt_ld = 0; r.cnt_u_d = 0; r.fail = 0;
    r.addr = '0;  r.d_in = '0;   r.faddr = '0;  r.wdata = '0;  r.felem = '0;
    return r;
  endfunction

  function automatic rec_t observe();
    rec_t r;
    r.cyc = cyc;          r.busy = bus.busy;       r.done = bus.done;
    r.mem_en = bus.mem_en; r.mem_we = bus.mem_we;  r.cnt_cen = bus.cnt_cen;
    r.cnt_ld = bus.cnt_ld; r.cnt_u_d = bus.cnt_u_d; r.fail = bus.fail;
    r.addr = bus.mem_addr; r.d_in = bus.cnt_d_in;  r.faddr = bus.fail_addr;
    r.wdata = bus.mem_wdata; r.felem = bus.fail_elem;
    return r;
  endfunction

  // Fields that only matter under their qualifier are zeroed
  function automatic logic [31:0] canon(rec_t r);
    return {7'd0, r.busy, r.done, r.mem_en, r.mem_en & r.mem_we,
            (r.mem_en && r.mem_we) ? r.wdata : DW'(0), r.mem_en ? r.addr : AW'(0),
            r.cnt_cen, r.cnt_cen & r.cnt_ld, r.cnt_cen & ~r.cnt_ld & r.cnt_u_d,
            (r.cnt_cen && r.cnt_ld) ? r.d_in : AW'(0), r.fail, r.faddr, r.felem};
  endfunction

  // March C- reference: expand elements into cycles 1..49 after start at cycle 0
  task automatic build(input int base, input int rst_at);
    bit up [6]      = '{1, 1, 1, 0, 0, 1};
    int nop [6]     = '{1, 2, 2, 2, 2, 1};
    bit isrd [6][2] = '{'{0, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}, '{1, 0}};
    bit val [6][2]  = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    logic [DW-1:0] m [NA];
    logic [DW-1:0] bg;
    rec_t raw[$];
    rec_t r;
    int fcyc = 1000;
    logic [AW-1:0] fa = '0;
    logic [2:0] fe = '0;
    for (int e = 0; e < 6; e++) begin
      r = idle_rec(); r.busy = 1; r.cnt_cen = 1; r.cnt_ld = 1;
      r.d_in = up[e] ? AW'(0) : AW'(NA - 1);
      raw.push_back(r);
      for (int i = 0; i < NA; i++) begin
        int a = up[e] ? i : NA - 1 - i;
        for (int o = 0; o < nop[e]; o++) begin
          bg = val[e][o] ? '1 : '0;
          r = idle_rec(); r.busy = 1; r.mem_en = 1; r.mem_we = !isrd[e][o];
          r.addr = AW'(a); r.wdata = bg;
          if (isrd[e][o]) begin
            if (faulty(a, m[a]) != bg && fcyc == 1000) begin
              fcyc = raw.size() + 1 + 2;
              fa = AW'(a);
              fe = 3'(e);
            end
          end else begin
            m[a] = bg;
          end
          if (o == nop[e] - 1 && i != NA - 1) begin
            r.cnt_cen = 1; r.cnt_u_d = up[e];
          end
          raw.push_back(r);
        end
      end
    end
    r = idle_rec(); r.busy = 1; raw.push_back(r);
    r = idle_rec(); r.done = 1; raw.push_back(r);
    r = idle_rec(); raw.push_back(r);
    for (int j = 0; j < raw.size(); j++) begin
      int k = j + 1;
      r = raw[j];
`ifdef MBIST_FAIL_STOP_EN
      if (k > fcyc + 1) break;
      if (k == fcyc) begin r = idle_rec(); r.done = 1; end
      if (k == fcyc + 1) r = idle_rec();
`endif
      if (k >= fcyc) begin r.fail = 1; r.faddr = fa; r.felem = fe; end
      if (rst_at > 0 && k == rst_at + 1) begin
        r = idle_rec(); r.cyc = base + k; exp_q.push_back(r);
        break;
      end
      r.cyc = base + k;
      exp_q.push_back(r);
    end
  endtask

  // Monitor: compare every expected cycle record against the DUT
  always @(negedge clk) begin
    rec_t e, o;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      o = observe();
      n_cmp++;
      if (e.cyc != cyc || canon(o) != canon(e)) begin
        n_bad++;
        $display("FAIL cycle_rec @%0d (due %0d): got %08h required %08h", cyc, e.cyc,
                 canon(o), canon(e));
      end
    end
  end

  task automatic run(input int rst_at, input int busy_at, input int end_c);
    @(posedge clk); #1;
    build(cyc, rst_at);
    bus.start = 1'b1;
    for (int c = 1; c <= end_c; c++) begin
      @(posedge clk); #1;
      bus.start = (c == busy_at);
      rst       = (c == rst_at);
    end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rec_t r;
    int max_busy;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    r = idle_rec(); r.cyc = cyc; exp_q.push_back(r);
    @(posedge clk); #1;

`ifdef MBIST_FAIL_STOP_EN
    max_busy = 8;
`else
    max_busy = 46;
`endif
    // Fault-free run with a stray start while busy
    flt_en = 0;
    run(0, 10, 52);
    // Stuck-at-1 bit 0 at address 2
    flt_en = 1; flt_addr = 2; flt_bit = 0; flt_val = 1;
    run(0, (max_busy < 20) ? 5 : 20, 52);
    // Reset mid-run, then a clean full run
    run(20, 0, 23);
    flt_en = 0;
    run(0, 0, 52);
    // Randomised faults and stray starts
    for (int t = 0; t < 8; t++) begin
      flt_en   = ($urandom_range(0, 3) != 0);
      flt_addr = $urandom_range(0, NA - 1);
      flt_bit  = $urandom_range(0, DW - 1);
      flt_val  = 1'($urandom_range(0, 1));
      run(0, $urandom_range(1, max_busy), 52);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end
endmodule
